// File: rtl/uart_frame_parser_pkg.sv
// uart_frame_pkg: parser states, header bytes and error codes shared by the frame parser files.
package uart_frame_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_CMD, S_LEN, S_DATA
`ifdef FRAME_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;
  localparam logic [7:0] HDR_1 = 8'hAA;
  localparam logic [7:0] HDR_2 = 8'h55;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;
endpackage

// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if: byte input strobe plus decoded frame outputs of the frame parser.
interface uart_frame_parser_if #(parameter int MAX_LEN = 8);
  logic [7:0]           pi_data;
  logic                 pi_flag;
  logic                 frame_vld;
  logic [7:0]           frame_cmd;
  logic [3:0]           frame_len;
  logic [8*MAX_LEN-1:0] frame_payload;
  logic                 frame_err;
  logic [1:0]           err_code;
  modport master (output pi_data, pi_flag,
                  input frame_vld, frame_cmd, frame_len, frame_payload, frame_err, err_code);
  modport slave  (input pi_data, pi_flag,
                  output frame_vld, frame_cmd, frame_len, frame_payload, frame_err, err_code);
endinterface

// File: rtl/uart_frame_parser_timeout.sv
// frame_timeout: counts running idle clocks and pulses expire on the CYC-th; clear wins over expiry.
module frame_timeout #(
  parameter int CYC = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);
  localparam int TW = $clog2(CYC + 1);
  logic [TW-1:0] cnt_q;
  assign expire = run && !clear && cnt_q == TW'(CYC - 1);
  always_ff @(posedge clk)
    cnt_q <= (rst || clear || expire) ? '0 : run ? cnt_q + 1'b1 : cnt_q;
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: parses AA 55 CMD LEN payload [CHK] frames from a byte stream.
// Define FRAME_CHECKSUM_EN to expect and verify the trailing checksum byte.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TIMEOUT_CYC = 50_000,
  parameter int MAX_LEN     = 8
) (
  input logic              sys_clk,
  input logic              sys_rst,
  uart_frame_parser_if.slave bus
);
  localparam int PW = 8 * MAX_LEN;
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  if (CLK_FREQ <= 0 || TIMEOUT_CYC <= 0 || MAX_LEN < 1 || MAX_LEN > 15) begin : g_bad_cfg
    $error("uart_frame_parser: unsupported parameter values");
  end
  state_e        state_q;
  logic [7:0]    cmd_q, sum_q, out_cmd_q, sum_d;
  logic [3:0]    len_q, cnt_q, out_len_q;
  logic [PW-1:0] buf_q, buf_d, out_pay_q;
  logic          vld_q, err_q, expire;
  logic [1:0]    code_q;
  always_comb begin
    buf_d = buf_q;
    for (int i = 0; i < MAX_LEN; i++)
      if (cnt_q == i[3:0]) buf_d[8*i +: 8] = bus.pi_data;
  end
  assign sum_d = sum_q + bus.pi_data;
  frame_timeout #(.CYC(TIMEOUT_CYC)) u_timeout (
    .clk(sys_clk), .rst(sys_rst),
    .clear(bus.pi_flag || state_q == S_IDLE),
    .run(state_q != S_IDLE),
    .expire(expire)
  );
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      buf_q     <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      out_cmd_q <= '0;
      out_len_q <= '0;
      out_pay_q <= '0;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      if (bus.pi_flag) begin
        case (state_q)
          S_IDLE: state_q <= bus.pi_data == HDR_1 ? S_HDR2 : S_IDLE;
          S_HDR2: state_q <= bus.pi_data == HDR_2 ? S_CMD : bus.pi_data == HDR_1 ? S_HDR2 : S_IDLE;
          S_CMD: begin
            cmd_q   <= bus.pi_data;
            sum_q   <= bus.pi_data;
            buf_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_LEN;
          end
          S_LEN: begin
            len_q <= bus.pi_data[3:0];
            sum_q <= sum_d;
            if (bus.pi_data > MAX_B) begin
              err_q   <= 1'b1;
              code_q  <= ERR_LEN;
              state_q <= S_IDLE;
            end else if (bus.pi_data != 8'd0) begin
              state_q <= S_DATA;
            end else begin
`ifdef FRAME_CHECKSUM_EN
              state_q <= S_CHK;
`else
              vld_q     <= 1'b1;
              out_cmd_q <= cmd_q;
              out_len_q <= 4'd0;
              out_pay_q <= '0;
              state_q   <= S_IDLE;
`endif
            end
          end
          S_DATA: begin
            buf_q <= buf_d;
            sum_q <= sum_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == len_q - 4'd1) begin
`ifdef FRAME_CHECKSUM_EN
              state_q <= S_CHK;
`else
              vld_q     <= 1'b1;
              out_cmd_q <= cmd_q;
              out_len_q <= len_q;
              out_pay_q <= buf_d;
              state_q   <= S_IDLE;
`endif
            end
          end
`ifdef FRAME_CHECKSUM_EN
          S_CHK: begin
            if (bus.pi_data == sum_q) begin
              vld_q     <= 1'b1;
              out_cmd_q <= cmd_q;
              out_len_q <= len_q;
              out_pay_q <= buf_q;
            end else begin
              err_q  <= 1'b1;
              code_q <= ERR_CHK;
            end
            state_q <= S_IDLE;
          end
`endif
          default: state_q <= S_IDLE;
        endcase
      end else if (expire) begin
        err_q   <= 1'b1;
        code_q  <= ERR_TMO;
        state_q <= S_IDLE;
      end
    end
  end
  assign bus.frame_vld     = vld_q;
  assign bus.frame_err     = err_q;
  assign bus.err_code      = code_q;
  assign bus.frame_cmd     = out_cmd_q;
  assign bus.frame_len     = out_len_q;
  assign bus.frame_payload = out_pay_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed frame vectors plus timing, timeout and reset sequences.
module tb_uart_frame_parser;
  localparam int TMO = 20;
`ifdef FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  typedef struct packed {
    logic [127:0] s;
    int           n;
    int           vld;
    int           err;
    logic [1:0]   code;
    logic [7:0]   cmd;
    logic [3:0]   len;
    logic [63:0]  pay;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_frame_parser_if #(.MAX_LEN(8)) bus();
  uart_frame_parser #(.TIMEOUT_CYC(TMO), .MAX_LEN(8)) dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));
  int compared = 0, mismatched = 0;
  int vld_tot = 0, err_tot = 0, both_tot = 0;
  always @(negedge clk) if (!rst) begin
    if (bus.frame_vld) vld_tot++;
    if (bus.frame_err) err_tot++;
    if (bus.frame_vld && bus.frame_err) both_tot++;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    bus.pi_data = b;
    bus.pi_flag = 1'b1;
    @(posedge clk);
    #1 bus.pi_flag = 1'b0;
  endtask
  task automatic send_seq(input logic [127:0] s, input int n);
    for (int i = 0; i < n; i++) send(s[(n-1-i)*8 +: 8]);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check_outs(input string tag, input logic [1:0] code, input logic [7:0] cmd,
                            input logic [3:0] len, input logic [63:0] pay);
    check({tag, "_code"}, 64'(bus.err_code), 64'(code));
    check({tag, "_cmd"}, 64'(bus.frame_cmd), 64'(cmd));
    check({tag, "_len"}, 64'(bus.frame_len), 64'(len));
    check({tag, "_pay"}, bus.frame_payload, pay);
  endtask
  vec_t tv[9];
  int v0, e0;
  initial begin
    bus.pi_data = 8'h00;
    bus.pi_flag = 1'b0;
    tv[0] = '{s:128'hAA551002123458, n:7, vld:1, err:0, code:2'd0, cmd:8'h10, len:4'd2, pay:64'h3412};
    tv[1] = '{s:128'hAA551002123459, n:7, vld:CK ? 0 : 1, err:CK ? 1 : 0, code:CK ? 2'd2 : 2'd0,
              cmd:8'h10, len:4'd2, pay:64'h3412};
    tv[2] = '{s:128'hAA550109, n:4, vld:0, err:1, code:2'd1, cmd:8'h10, len:4'd2, pay:64'h3412};
    tv[3] = '{s:128'hAA55070301020310, n:8, vld:1, err:0, code:2'd1, cmd:8'h07, len:4'd3, pay:64'h030201};
    tv[4] = '{s:128'hAAAA55200020, n:6, vld:1, err:0, code:2'd1, cmd:8'h20, len:4'd0, pay:64'h0};
    tv[5] = '{s:128'hAA55FF02FFFFFF, n:7, vld:1, err:0, code:2'd1, cmd:8'hFF, len:4'd2, pay:64'hFFFF};
    tv[6] = '{s:128'h12AA34AA55420801020304050607086E, n:16, vld:1, err:0, code:2'd1, cmd:8'h42, len:4'd8,
              pay:64'h0807060504030201};
    tv[7] = '{s:128'hAA5533015A8E, n:6, vld:1, err:0, code:2'd1, cmd:8'h33, len:4'd1, pay:64'h5A};
    tv[8] = '{s:128'hAA5501FF, n:4, vld:0, err:1, code:2'd1, cmd:8'h33, len:4'd1, pay:64'h5A};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", 64'(bus.frame_vld), 64'd0);
    check("rst_err", 64'(bus.frame_err), 64'd0);
    check_outs("rst", 2'd0, 8'h00, 4'd0, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    for (int i = 0; i < 9; i++) begin
      v0 = vld_tot;
      e0 = err_tot;
      send_seq(tv[i].s, tv[i].n);
      idle(3);
      check($sformatf("v%0d_vld", i), 64'(vld_tot - v0), 64'(tv[i].vld));
      check($sformatf("v%0d_err", i), 64'(err_tot - e0), 64'(tv[i].err));
      check_outs($sformatf("v%0d", i), tv[i].code, tv[i].cmd, tv[i].len, tv[i].pay);
    end
    // frame_vld must rise in the cycle right after the last byte and last one cycle
    send_seq(128'hAA5510021234, 6);
    if (CK) send(8'h58);
    @(negedge clk);
    check("vld_timing", 64'(bus.frame_vld), 64'd1);
    check("vld_timing_err", 64'(bus.frame_err), 64'd0);
    check_outs("vld_timing", 2'd1, 8'h10, 4'd2, 64'h3412);
    @(negedge clk);
    check("vld_one_cycle", 64'(bus.frame_vld), 64'd0);
    @(posedge clk);
    #1;
    e0 = err_tot;
    send_seq(128'hAA5501, 3);
    for (int k = 1; k <= TMO + 1; k++) begin
      @(negedge clk);
      if (k == TMO) check("tmo_early", 64'(bus.frame_err), 64'd0);
      if (k == TMO + 1) begin
        check("tmo_pulse", 64'(bus.frame_err), 64'd1);
        check("tmo_code", 64'(bus.err_code), 64'd3);
      end
    end
    idle(TMO + 5);
    check("tmo_once", 64'(err_tot - e0), 64'd1);
    check_outs("tmo", 2'd3, 8'h10, 4'd2, 64'h3412);
    // a byte arriving on the expiry clock must beat the timeout
    send_seq(128'hAA5501, 3);
    repeat (TMO - 1) @(posedge clk);
    #1;
    e0 = err_tot;
    v0 = vld_tot;
    send(8'h00);
    if (CK) send(8'h01);
    idle(3);
    check("coinc_err", 64'(err_tot - e0), 64'd0);
    check("coinc_vld", 64'(vld_tot - v0), 64'd1);
    check_outs("coinc", 2'd3, 8'h01, 4'd0, 64'h0);
    e0 = err_tot;
    v0 = vld_tot;
    send_seq(128'hAA55770311, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_vld", 64'(bus.frame_vld), 64'd0);
    check("rst_mid_err", 64'(bus.frame_err), 64'd0);
    check_outs("rst_mid", 2'd0, 8'h00, 4'd0, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h22);
    send(8'h33);
    idle(TMO + 5);
    check("rst_mid_no_err", 64'(err_tot - e0), 64'd0);
    check("rst_mid_no_vld", 64'(vld_tot - v0), 64'd0);
    check("vld_err_exclusive", 64'(both_tot), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
